// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator pipeline.
// Holds the immediate format codes and the default field widths used by
// imm_field_extract and imm_gen_pipe.
package imm_gen_pipe_pkg;

  localparam int DEF_WORD_LENGTH = 32;
  localparam int DEF_SHORT_LEN   = 18;
  localparam int DEF_LONG_LEN    = 22;

  // Codes 5..7 are illegal and produce y = 0 with err = 1.
  localparam logic [2:0] FMT_ZERO = 3'd0;
  localparam logic [2:0] FMT_SIMM = 3'd1;
  localparam logic [2:0] FMT_UIMM = 3'd2;
  localparam logic [2:0] FMT_LIMM = 3'd3;
  localparam logic [2:0] FMT_FUSE = 3'd4;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational immediate field extraction and extension.
// Ports:
//   instr      - instruction word
//   fmt        - immediate format code
//   held       - upper part captured by the most recent LIMM
//   hold_valid - held is valid for fusing
//   y          - generated immediate
//   err        - illegal format, or FUSE with no held upper part
module imm_field_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int SHORT_LEN   = DEF_SHORT_LEN,
  parameter int LONG_LEN    = DEF_LONG_LEN
) (
  input  logic [WORD_LENGTH-1:0] instr,
  input  logic [2:0]             fmt,
  input  logic [WORD_LENGTH-1:0] held,
  input  logic                   hold_valid,
  output logic [WORD_LENGTH-1:0] y,
  output logic                   err
);
  // Width of the low part a FUSE contributes below the LIMM upper part.
  localparam int LOW_LEN = WORD_LENGTH - LONG_LEN;

  logic [WORD_LENGTH-1:0] simm, uimm, limm, fuse_lo;
  logic                   unused_hi;

  assign simm    = {{(WORD_LENGTH-SHORT_LEN){instr[SHORT_LEN-1]}}, instr[SHORT_LEN-1:0]};
  assign uimm    = {{(WORD_LENGTH-SHORT_LEN){1'b0}}, instr[SHORT_LEN-1:0]};
  assign limm    = {instr[LONG_LEN-1:0], {LOW_LEN{1'b0}}};
  assign fuse_lo = {{LONG_LEN{1'b0}}, instr[LOW_LEN-1:0]};
  // Opcode bits above the long field never feed an immediate.
  assign unused_hi = ^instr[WORD_LENGTH-1:LONG_LEN];

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (fmt)
      FMT_ZERO: y = '0;
      FMT_SIMM: y = simm;
      FMT_UIMM: y = uimm;
      FMT_LIMM: y = limm;
      FMT_FUSE: begin
        y   = hold_valid ? (held | fuse_lo) : fuse_lo;
        err = ~hold_valid;
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready handshakes.
// Stage 1 captures instr/fmt plus a snapshot of the held LIMM upper part;
// stage 2 registers the extracted y/err.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop both stages and the held upper part
//   in_valid/in_ready   - input handshake for instr/fmt
//   out_valid/out_ready - output handshake for y/err
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int SHORT_LEN   = DEF_SHORT_LEN,
  parameter int LONG_LEN    = DEF_LONG_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] instr,
  input  logic [2:0]             fmt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] y,
  output logic                   err
);
  localparam int LOW_LEN = WORD_LENGTH - LONG_LEN;

  logic [2:1]             vld_q, vld_d;
  logic [WORD_LENGTH-1:0] s1_instr_q, s1_instr_d;
  logic [2:0]             s1_fmt_q, s1_fmt_d;
  logic [WORD_LENGTH-1:0] s1_held_q, s1_held_d;
  logic                   s1_hv_q, s1_hv_d;
  logic [WORD_LENGTH-1:0] y_q, y_d;
  logic                   err_q, err_d;
  logic [WORD_LENGTH-1:0] held_q, held_d;
  logic                   hold_valid_q, hold_valid_d;

  logic                   s2_adv, accept, ext_err;
  logic [WORD_LENGTH-1:0] ext_y;

  imm_field_extract #(
    .WORD_LENGTH(WORD_LENGTH),
    .SHORT_LEN  (SHORT_LEN),
    .LONG_LEN   (LONG_LEN)
  ) u_extract (
    .instr     (s1_instr_q),
    .fmt       (s1_fmt_q),
    .held      (s1_held_q),
    .hold_valid(s1_hv_q),
    .y         (ext_y),
    .err       (ext_err)
  );

  always_comb begin
    s2_adv   = ~vld_q[2] | out_ready;
    in_ready = ~rst & ~flush & (~vld_q[1] | s2_adv);
    accept   = in_valid & in_ready;

    vld_d        = vld_q;
    s1_instr_d   = s1_instr_q;
    s1_fmt_d     = s1_fmt_q;
    s1_held_d    = s1_held_q;
    s1_hv_d      = s1_hv_q;
    y_d          = y_q;
    err_d        = err_q;
    held_d       = held_q;
    hold_valid_d = hold_valid_q;

    if (s2_adv) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) begin
        y_d   = ext_y;
        err_d = ext_err;
      end
    end

    if (~vld_q[1] | s2_adv) vld_d[1] = accept;

    // The held register is updated in accept order, so the snapshot taken
    // here already reflects a LIMM accepted on the previous cycle; that is
    // what makes LIMM->FUSE back-to-back work with no bypass mux.
    if (accept) begin
      s1_instr_d = instr;
      s1_fmt_d   = fmt;
      s1_held_d  = held_q;
      s1_hv_d    = hold_valid_q;
      if (fmt == FMT_LIMM) begin
        held_d       = {instr[LONG_LEN-1:0], {LOW_LEN{1'b0}}};
        hold_valid_d = 1'b1;
      end else if (fmt == FMT_FUSE) begin
        hold_valid_d = 1'b0;
      end
    end

    if (flush) begin
      vld_d        = '0;
      held_d       = '0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      s1_instr_q   <= '0;
      s1_fmt_q     <= '0;
      s1_held_q    <= '0;
      s1_hv_q      <= 1'b0;
      y_q          <= '0;
      err_q        <= 1'b0;
      held_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      s1_instr_q   <= s1_instr_d;
      s1_fmt_q     <= s1_fmt_d;
      s1_held_q    <= s1_held_d;
      s1_hv_q      <= s1_hv_d;
      y_q          <= y_d;
      err_q        <= err_d;
      held_q       <= held_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign out_valid = vld_q[2];
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (32/18/22). Driver changes inputs just
// after the rising edge; the monitor samples on the falling edge, predicts
// each accepted item with plain arithmetic and checks it on retire.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] instr, y;
  logic [2:0]  fmt;

  always #5 clk = ~clk;

  imm_gen_pipe #(.WORD_LENGTH(32), .SHORT_LEN(18), .LONG_LEN(22)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err)
  );

  typedef struct { logic [31:0] y; logic err; int cyc; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc_n = 0, n_ret = 0, drop_cnt = 0, last_lat = 0;
  logic [31:0] last_y = '0, prev_y = '0, m_held = '0;
  logic last_err = 1'b0, prev_err = 1'b0, m_hv = 1'b0;
  logic prev_rst = 1'b0, prev_flush = 1'b0, prev_stall = 1'b0;
  int r, base_drop, base_ret;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  // Reference: immediate rules stated as arithmetic on field values.
  function automatic exp_t predict(input logic [2:0] f, input logic [31:0] ins);
    exp_t e;
    logic [31:0] v;
    e.y = 32'd0; e.err = 1'b0; e.cyc = cyc_n;
    case (f)
      3'd0: e.y = 32'd0;
      3'd1: begin
        v = ins % 32'd262144;
        e.y = (v >= 32'd131072) ? v - 32'd262144 : v;
      end
      3'd2: e.y = ins % 32'd262144;
      3'd3: begin
        e.y = (ins % 32'd4194304) * 32'd1024;
        m_held = e.y; m_hv = 1'b1;
      end
      3'd4: begin
        v = ins % 32'd1024;
        e.y = m_hv ? (m_held | v) : v;
        e.err = ~m_hv;
        m_hv = 1'b0;
      end
      default: begin e.y = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (prev_rst) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd1 - 32'd1);
      chk("rst_y", y, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      if (!rst && !flush) chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    end else if (prev_flush) begin
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    end else if (prev_stall) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_y", y, prev_y);
      chk("stall_err", {31'd0, err}, {31'd0, prev_err});
    end
    if (rst) begin
      chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      sb.delete(); m_held = '0; m_hv = 1'b0;
    end else begin
      if (flush) chk("in_ready_in_flush", {31'd0, in_ready}, 32'd0);
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output act=%h exp=none", y);
        end else begin
          e = sb.pop_front();
          chk("y", y, e.y);
          chk("err", {31'd0, err}, {31'd0, e.err});
          last_lat = cyc_n - e.cyc;
          chk("latency_min", {31'd0, (last_lat >= 2)}, 32'd1);
          last_y = y; last_err = err; n_ret++;
        end
      end
      if (flush) begin
        sb.delete(); m_held = '0; m_hv = 1'b0;
      end else begin
        if (in_valid && in_ready === 1'b1) sb.push_back(predict(fmt, instr));
        if (in_valid && in_ready === 1'b0) drop_cnt++;
      end
    end
    prev_rst   = rst;
    prev_flush = flush && !rst;
    prev_stall = !rst && !flush && out_valid === 1'b1 && !out_ready;
    prev_y     = y;
    prev_err   = err;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] ins);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; fmt = f; instr = ins;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout act=not_accepted exp=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 50) begin
      cyc(); n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; fmt = '0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Sign extension from the top of the short field, 2-cycle latency.
    send(3'd1, 32'h0002_0000);
    drain();
    chk("simm_y", last_y, 32'hFFFE_0000);
    chk("simm_lat", last_lat, 32'd2);

    // LIMM then FUSE back-to-back.
    send(3'd3, 32'h003F_FFFF);
    send(3'd4, 32'h0000_0155);
    drain();
    chk("fuse_y", last_y, 32'hFFFF_FD55);
    chk("fuse_err", {31'd0, last_err}, 32'd0);

    // FUSE without held part, then illegal format.
    rst = 1'b1; cyc(); rst = 1'b0;
    send(3'd4, 32'h0000_0155);
    drain();
    chk("lone_fuse_y", last_y, 32'h0000_0155);
    chk("lone_fuse_err", {31'd0, last_err}, 32'd1);
    send(3'd6, 32'hDEAD_BEEF);
    drain();
    chk("illegal_y", last_y, 32'd0);
    chk("illegal_err", {31'd0, last_err}, 32'd1);

    // Stream of 4 SIMMs with a 3-cycle consumer stall mid-stream.
    base_drop = drop_cnt; base_ret = n_ret;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 4; k++) send(3'd1, $urandom);
      end
    join
    drain();
    chk("stall_in_ready_dropped", {31'd0, (drop_cnt > base_drop)}, 32'd1);
    chk("stall_retire_count", n_ret - base_ret, 32'd4);

    // Flushed LIMM must neither output nor leave a held part.
    send(3'd3, $urandom);
    flush = 1'b1; in_valid = 1'b1; fmt = 3'd2; instr = 32'h1234_5678;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    send(3'd4, 32'h0000_0155);
    drain();
    chk("post_flush_fuse_y", last_y, 32'h0000_0155);
    chk("post_flush_fuse_err", {31'd0, last_err}, 32'd1);

    // Reset while stalled discards the pending output.
    out_ready = 1'b0;
    send(3'd1, $urandom);
    send(3'd2, $urandom);
    repeat (2) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    drain();

    // Random traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 9);
      fmt       = (r < 3) ? 3'd3 : (r < 6) ? 3'd4 : 3'($urandom_range(0, 7));
      instr     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
